mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 69 ++++++
 rtl/mem_stage_load_align.sv | 27 ++
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared decode constants, FSM encoding and request payload for the memory stage.
package mem_stage_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned CST_W  = 19;
    localparam int unsigned STRB_W = 8;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // MEM_Cst field positions
    localparam int unsigned CST_RF_WE_BIT = 0;
    localparam int unsigned CST_DR_LSB    = 1;
    localparam int unsigned CST_DR_MSB    = 5;
    localparam int unsigned CST_WB_SEL_LSB = 6;
    localparam int unsigned CST_WB_SEL_MSB = 7;

    // Request fields captured at issue and replayed into writeback
    typedef struct packed {
        logic             is_store;
        logic [2:0]       funct3;
        logic [2:0]       lane;
        logic [ILEN-1:0]  ir;
        logic [CST_W-1:0] cst;
        logic [XLEN-1:0]  npc;
        logic [XLEN-1:0]  res;
    } req_t;

    // Low address bits that must be zero for an access of size 1<<sz
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [STRB_W-1:0] size_strb(input logic [1:0] sz);
        case (sz)
            2'd0:    size_strb = 8'h01;
            2'd1:    size_strb = 8'h03;
            2'd2:    size_strb = 8'h0F;
            default: size_strb = 8'hFF;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d, input logic [1:0] sz);
        case (sz)
            2'd0:    replicate = {8{d[7:0]}};
            2'd1:    replicate = {4{d[15:0]}};
            2'd2:    replicate = {2{d[31:0]}};
            default: replicate = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed lane of a 64-bit read beat and sign/zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_val_c
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted    = rdata >> {addr, 3'b000};
        load_val_c = shifted;
        case (funct3)
            F3_B:    load_val_c = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    load_val_c = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_val_c = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   load_val_c = {56'd0, shifted[7:0]};
            F3_HU:   load_val_c = {48'd0, shifted[15:0]};
            F3_WU:   load_val_c = {32'd0, shifted[31:0]};
            default: load_val_c = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access per load/store, waits for
// ACK or timeout, and registers the result into the writeback stage.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
)(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_V,
    input  logic [ILEN-1:0]   MEM_IR,
    input  logic [XLEN-1:0]   MEM_RES,
    input  logic [XLEN-1:0]   MEM_Address,
    input  logic [CST_W-1:0]  MEM_Cst,
    input  logic [XLEN-1:0]   MEM_NPC,
    input  logic [XLEN-1:0]   MEM_Target_Address,
    input  logic              MEM_PC_MUX,
    output logic              MEM_STALL,
    output logic              MEM_FE_PC_MUX,
    output logic [XLEN-1:0]   MEM_FE_Target,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [XLEN-1:0]   DMEM_ADDR,
    output logic [XLEN-1:0]   DMEM_WDATA,
    output logic [STRB_W-1:0] DMEM_WSTRB,
    input  logic              DMEM_ACK,
    input  logic [XLEN-1:0]   DMEM_RDATA,
    output logic              WB_V,
    output logic [XLEN-1:0]   WB_RES,
    output logic [ILEN-1:0]   WB_IR,
    output logic [CST_W-1:0]  WB_Cst,
    output logic [XLEN-1:0]   WB_NPC,
    output logic              WB_EXC
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [0:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    req_t             req_q, req_d;

    logic              dmem_req_d, dmem_we_d;
    logic [XLEN-1:0]   dmem_addr_d, dmem_wdata_d;
    logic [STRB_W-1:0] dmem_wstrb_d;
    logic              wb_v_d, wb_exc_d;
    logic [XLEN-1:0]   wb_res_d, wb_npc_d;
    logic [ILEN-1:0]   wb_ir_d;
    logic [CST_W-1:0]  wb_cst_d;

    logic              is_load, is_store, mem_op, misaligned;
    logic              in_wait, ack_done, timed_out;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   load_val;

    assign funct3     = MEM_IR[14:12];
    assign is_load    = (MEM_IR[6:2] == OP_LOAD);
    assign is_store   = (MEM_IR[6:2] == OP_STORE);
    assign mem_op     = MEM_V && (is_load || is_store);
    assign misaligned = |(MEM_Address[2:0] & align_mask(funct3[1:0]));
    assign in_wait    = (state == ST_WAIT);
    assign ack_done   = in_wait && DMEM_ACK;
    assign timed_out  = in_wait && (cnt == CNT_W'(TIMEOUT));

    assign MEM_STALL     = mem_op && !misaligned && !ack_done && !timed_out;
    assign MEM_FE_PC_MUX = MEM_V && MEM_PC_MUX;
    assign MEM_FE_Target = MEM_Target_Address;

    load_align u_load_align (
        .rdata      (DMEM_RDATA),
        .addr       (req_q.lane),
        .funct3     (req_q.funct3),
        .load_val_c (load_val)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        req_d        = req_q;
        dmem_req_d   = DMEM_REQ;
        dmem_we_d    = DMEM_WE;
        dmem_addr_d  = DMEM_ADDR;
        dmem_wdata_d = DMEM_WDATA;
        dmem_wstrb_d = DMEM_WSTRB;
        wb_v_d       = 1'b0;
        wb_exc_d     = 1'b0;
        wb_res_d     = WB_RES;
        wb_ir_d      = WB_IR;
        wb_cst_d     = WB_Cst;
        wb_npc_d     = WB_NPC;

        if (state == ST_IDLE) begin
            if (mem_op && misaligned) begin
                wb_v_d   = 1'b1;
                wb_exc_d = 1'b1;
                wb_res_d = MEM_Address;
                wb_ir_d  = MEM_IR;
                wb_cst_d = MEM_Cst;
                wb_npc_d = MEM_NPC;
            end else if (mem_op) begin
                dmem_req_d     = 1'b1;
                dmem_we_d      = is_store;
                dmem_addr_d    = {MEM_Address[XLEN-1:3], 3'b000};
                dmem_wdata_d   = replicate(MEM_RES, funct3[1:0]);
                dmem_wstrb_d   = STRB_W'(size_strb(funct3[1:0]) << MEM_Address[2:0]);
                req_d.is_store = is_store;
                req_d.funct3   = funct3;
                req_d.lane     = MEM_Address[2:0];
                req_d.ir       = MEM_IR;
                req_d.cst      = MEM_Cst;
                req_d.npc      = MEM_NPC;
                req_d.res      = MEM_RES;
                cnt_d          = '0;
                state_d        = ST_WAIT;
            end else begin
                wb_v_d   = MEM_V;
                wb_res_d = MEM_RES;
                wb_ir_d  = MEM_IR;
                wb_cst_d = MEM_Cst;
                wb_npc_d = MEM_NPC;
            end
        end else begin
            if (DMEM_ACK || timed_out) begin
                dmem_req_d   = 1'b0;
                dmem_we_d    = 1'b0;
                dmem_wstrb_d = '0;
                wb_v_d       = 1'b1;
                wb_exc_d     = !DMEM_ACK;
                wb_ir_d      = req_q.ir;
                wb_cst_d     = req_q.cst;
                wb_npc_d     = req_q.npc;
                state_d      = ST_IDLE;
                // A faulting access reports its own address
                if (!DMEM_ACK)
                    wb_res_d = {DMEM_ADDR[XLEN-1:3], req_q.lane};
                else if (req_q.is_store)
                    wb_res_d = req_q.res;
                else
                    wb_res_d = load_val;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_q      <= '0;
            DMEM_REQ   <= 1'b0;
            DMEM_WE    <= 1'b0;
            DMEM_ADDR  <= '0;
            DMEM_WDATA <= '0;
            DMEM_WSTRB <= '0;
            WB_V       <= 1'b0;
            WB_EXC     <= 1'b0;
            WB_RES     <= '0;
            WB_IR      <= '0;
            WB_Cst     <= '0;
            WB_NPC     <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            req_q      <= req_d;
            DMEM_REQ   <= dmem_req_d;
            DMEM_WE    <= dmem_we_d;
            DMEM_ADDR  <= dmem_addr_d;
            DMEM_WDATA <= dmem_wdata_d;
            DMEM_WSTRB <= dmem_wstrb_d;
            WB_V       <= wb_v_d;
            WB_EXC     <= wb_exc_d;
            WB_RES     <= wb_res_d;
            WB_IR      <= wb_ir_d;
            WB_Cst     <= wb_cst_d;
            WB_NPC     <= wb_npc_d;
        end
    end

endmodule
